// File: rtl/alu_issue_ctrl.sv
// Issue/retire controller around a combinational RV32I ALU: decodes micro-ops into
// ALU control and operands (S1), captures result and flags (S2), and resolves branches.
module alu_issue_ctrl #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       in_opcode,
  input  logic [2:0]       in_funct3,
  input  logic             in_funct7b5,
  input  logic [XLEN-1:0]  in_rs1_val,
  input  logic [XLEN-1:0]  in_rs2_val,
  input  logic [XLEN-1:0]  in_imm,
  output logic [3:0]       ALU_control,
  output logic [XLEN-1:0]  alu_I1,
  output logic [XLEN-1:0]  alu_I2,
  input  logic [XLEN-1:0]  alu_out,
  input  logic             alu_N,
  input  logic             alu_Z,
  input  logic             alu_C,
  input  logic             alu_V,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic             out_is_branch,
  output logic             out_taken,
  output logic             out_illegal,
  output logic [CNT_W-1:0] retired_cnt
);

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_XOR  = 4'b0010;
  localparam logic [3:0] ALU_ADD  = 4'b0011;
  localparam logic [3:0] ALU_SUB  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SLL  = 4'b0110;
  localparam logic [3:0] ALU_LTU  = 4'b1010;
  localparam logic [3:0] ALU_EQ   = 4'b1011;
  localparam logic [3:0] ALU_IDLE = 4'b1111;

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;
  localparam logic [6:0] OP_B = 7'b1100011;

  typedef enum logic [1:0] {SEL_ALU, SEL_SLT, SEL_ZERO} sel_e;
  typedef enum logic [1:0] {BR_EQ, BR_LT, BR_LTU} brk_e;

  // S1 state
  logic            s1_valid_q;
  logic [3:0]      s1_ctrl_q,  s1_ctrl_d;
  logic [XLEN-1:0] s1_i1_q,    s1_i1_d;
  logic [XLEN-1:0] s1_i2_q,    s1_i2_d;
  sel_e            s1_sel_q,   s1_sel_d;
  logic            s1_br_q,    s1_br_d;
  brk_e            s1_brk_q,   s1_brk_d;
  logic            s1_inv_q,   s1_inv_d;
  logic            s1_ill_q,   s1_ill_d;

  // S2 state
  logic             s2_valid_q;
  logic [XLEN-1:0]  s2_res_q,  s2_res_d;
  logic             s2_br_q;
  logic             s2_tk_q,   s2_tk_d;
  logic             s2_ill_q;
  logic [CNT_W-1:0] cnt_q;

  logic s1_load, s2_load, s2_drain;
  logic is_r, dec_ill;
  logic [XLEN-1:0] opnd_b, shamt;

  assign in_ready = !s1_valid_q || !s2_valid_q || out_ready;
  assign s1_load  = in_valid && in_ready;
  assign s2_load  = s1_valid_q && (!s2_valid_q || out_ready);
  assign s2_drain = s2_valid_q && out_ready;

  assign is_r   = (in_opcode == OP_R);
  assign opnd_b = is_r ? in_rs2_val : in_imm;
  assign shamt  = is_r ? in_rs2_val : {{(XLEN-5){1'b0}}, in_imm[4:0]};

  always_comb begin
    s1_ctrl_d = ALU_IDLE;
    s1_i1_d   = in_rs1_val;
    s1_i2_d   = opnd_b;
    s1_sel_d  = SEL_ALU;
    s1_br_d   = 1'b0;
    s1_brk_d  = BR_EQ;
    s1_inv_d  = 1'b0;
    dec_ill   = 1'b0;
    case (in_opcode)
      OP_R, OP_I: begin
        case (in_funct3)
          3'b000: s1_ctrl_d = (is_r && in_funct7b5) ? ALU_SUB : ALU_ADD;
          3'b001: begin
            s1_ctrl_d = ALU_SLL;
            s1_i2_d   = shamt;
          end
          3'b010: begin
            s1_ctrl_d = ALU_SUB;
            s1_sel_d  = SEL_SLT;
          end
          3'b011: s1_ctrl_d = ALU_LTU;
          3'b100: s1_ctrl_d = ALU_XOR;
          3'b101: begin
            // Arithmetic right shift has no ALU support.
            dec_ill   = in_funct7b5;
            s1_ctrl_d = ALU_SRL;
            s1_i2_d   = shamt;
          end
          3'b110: s1_ctrl_d = ALU_OR;
          default: s1_ctrl_d = ALU_AND;
        endcase
      end
      OP_B: begin
        s1_i2_d  = in_rs2_val;
        s1_sel_d = SEL_ZERO;
        s1_br_d  = 1'b1;
        s1_inv_d = in_funct3[0];
        case (in_funct3[2:1])
          2'b00: begin
            s1_ctrl_d = ALU_EQ;
            s1_brk_d  = BR_EQ;
          end
          2'b10: begin
            s1_ctrl_d = ALU_SUB;
            s1_brk_d  = BR_LT;
          end
          2'b11: begin
            s1_ctrl_d = ALU_LTU;
            s1_brk_d  = BR_LTU;
          end
          default: dec_ill = 1'b1;
        endcase
      end
      default: dec_ill = 1'b1;
    endcase
    s1_ill_d = dec_ill;
    if (dec_ill) begin
      s1_ctrl_d = ALU_IDLE;
      s1_i1_d   = '0;
      s1_i2_d   = '0;
      s1_sel_d  = SEL_ZERO;
      s1_br_d   = 1'b0;
      s1_inv_d  = 1'b0;
    end
  end

  // An emptied S1 parks the ALU on IDLE with zero operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_ctrl_q  <= ALU_IDLE;
      s1_i1_q    <= '0;
      s1_i2_q    <= '0;
      s1_sel_q   <= SEL_ZERO;
      s1_br_q    <= 1'b0;
      s1_brk_q   <= BR_EQ;
      s1_inv_q   <= 1'b0;
      s1_ill_q   <= 1'b0;
    end else if (s1_load) begin
      s1_valid_q <= 1'b1;
      s1_ctrl_q  <= s1_ctrl_d;
      s1_i1_q    <= s1_i1_d;
      s1_i2_q    <= s1_i2_d;
      s1_sel_q   <= s1_sel_d;
      s1_br_q    <= s1_br_d;
      s1_brk_q   <= s1_brk_d;
      s1_inv_q   <= s1_inv_d;
      s1_ill_q   <= s1_ill_d;
    end else if (s2_load) begin
      s1_valid_q <= 1'b0;
      s1_ctrl_q  <= ALU_IDLE;
      s1_i1_q    <= '0;
      s1_i2_q    <= '0;
      s1_sel_q   <= SEL_ZERO;
      s1_br_q    <= 1'b0;
      s1_brk_q   <= BR_EQ;
      s1_inv_q   <= 1'b0;
      s1_ill_q   <= 1'b0;
    end
  end

  assign ALU_control = s1_ctrl_q;
  assign alu_I1      = s1_i1_q;
  assign alu_I2      = s1_i2_q;

  logic signed_lt;
  assign signed_lt = alu_N ^ alu_V;

  always_comb begin
    case (s1_sel_q)
      SEL_ALU: s2_res_d = alu_out;
      SEL_SLT: s2_res_d = {{(XLEN-1){1'b0}}, signed_lt};
      default: s2_res_d = '0;
    endcase
    s2_tk_d = 1'b0;
    if (s1_br_q) begin
      case (s1_brk_q)
        BR_LT:   s2_tk_d = signed_lt ^ s1_inv_q;
        default: s2_tk_d = alu_out[0] ^ s1_inv_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_res_q   <= '0;
      s2_br_q    <= 1'b0;
      s2_tk_q    <= 1'b0;
      s2_ill_q   <= 1'b0;
    end else if (s2_load) begin
      s2_valid_q <= 1'b1;
      s2_res_q   <= s2_res_d;
      s2_br_q    <= s1_br_q;
      s2_tk_q    <= s2_tk_d;
      s2_ill_q   <= s1_ill_q;
    end else if (s2_drain) begin
      s2_valid_q <= 1'b0;
      s2_res_q   <= '0;
      s2_br_q    <= 1'b0;
      s2_tk_q    <= 1'b0;
      s2_ill_q   <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (s2_drain && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign out_valid     = s2_valid_q;
  assign out_result    = s2_res_q;
  assign out_is_branch = s2_br_q;
  assign out_taken     = s2_tk_q;
  assign out_illegal   = s2_ill_q;
  assign retired_cnt   = cnt_q;

  // Z and C are not needed for any supported compare.
  logic unused_flags;
  assign unused_flags = alu_Z ^ alu_C;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural model of the 32-bit ALU it drives.
module tb_alu_issue_ctrl;
  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic        in_funct7b5;
  logic [31:0] in_rs1_val, in_rs2_val, in_imm;
  logic [3:0]  ALU_control;
  logic [31:0] alu_I1, alu_I2, alu_out;
  logic        alu_N, alu_Z, alu_C, alu_V;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic        out_is_branch, out_taken, out_illegal;
  logic [15:0] retired_cnt;

  int errors = 0;
  int checks = 0;
  int exp_cnt = 0;

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;
  localparam logic [6:0] OP_B = 7'b1100011;

  alu_issue_ctrl #(.XLEN(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7b5(in_funct7b5),
    .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val), .in_imm(in_imm),
    .ALU_control(ALU_control), .alu_I1(alu_I1), .alu_I2(alu_I2),
    .alu_out(alu_out), .alu_N(alu_N), .alu_Z(alu_Z), .alu_C(alu_C), .alu_V(alu_V),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_is_branch(out_is_branch), .out_taken(out_taken), .out_illegal(out_illegal),
    .retired_cnt(retired_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-cycle ALU model
  logic [32:0] wide;
  always_comb begin
    wide  = 33'd0;
    alu_V = 1'b0;
    case (ALU_control)
      4'b0000: wide = {1'b0, alu_I1 & alu_I2};
      4'b0001: wide = {1'b0, alu_I1 | alu_I2};
      4'b0010: wide = {1'b0, alu_I1 ^ alu_I2};
      4'b0011: begin
        wide  = {1'b0, alu_I1} + {1'b0, alu_I2};
        alu_V = (alu_I1[31] == alu_I2[31]) && (wide[31] != alu_I1[31]);
      end
      4'b0100: begin
        wide  = {1'b0, alu_I1} + {1'b0, ~alu_I2} + 33'd1;
        alu_V = (alu_I1[31] != alu_I2[31]) && (wide[31] != alu_I1[31]);
      end
      4'b0101: wide = {1'b0, alu_I1 >> alu_I2[4:0]};
      4'b0110: wide = {1'b0, alu_I1 << alu_I2[4:0]};
      4'b1010: wide = {32'd0, alu_I1 < alu_I2};
      4'b1011: wide = {32'd0, alu_I1 == alu_I2};
      default: wide = 33'd0;
    endcase
    alu_out = wide[31:0];
    alu_N   = wide[31];
    alu_Z   = (wide[31:0] == 32'd0);
    alu_C   = wide[32];
  end

  task automatic set_op(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm);
    in_opcode   = opc;
    in_funct3   = f3;
    in_funct7b5 = f7;
    in_rs1_val  = a;
    in_rs2_val  = b;
    in_imm      = imm;
    in_valid    = 1'b1;
  endtask

  // Issues one op into an idle pipeline with out_ready high; starts and ends at posedge+1.
  task automatic send_op(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                         output logic [3:0] ctrl, output logic [31:0] i1, output logic [31:0] i2,
                         output logic ov, output logic [31:0] res,
                         output logic br, output logic tk, output logic ill);
    set_op(opc, f3, f7, a, b, imm);
    @(posedge clk); #1;
    in_valid = 1'b0;
    ctrl = ALU_control; i1 = alu_I1; i2 = alu_I2;
    @(posedge clk); #1;
    ov = out_valid; res = out_result; br = out_is_branch; tk = out_taken; ill = out_illegal;
    @(posedge clk); #1;
    exp_cnt++;
    $display("op opc=%b f3=%b f7=%b a=%h b=%h imm=%h -> ctrl=%b res=%h br=%b tk=%b ill=%b",
             opc, f3, f7, a, b, imm, ctrl, res, br, tk, ill);
  endtask

  logic [3:0]  c;
  logic [31:0] i1, i2, r;
  logic        ov, br, tk, il;

  task automatic test_reset();
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    set_op(OP_R, 3'b000, 1'b0, 32'd0, 32'd0, 32'd0);
    in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (ALU_control !== 4'b1111) begin errors++; $display("FAIL reset_ctrl got=%b exp=1111", ALU_control); end
    checks++; if (alu_I1 !== 32'd0 || alu_I2 !== 32'd0) begin errors++; $display("FAIL reset_operands got=%h/%h exp=0/0", alu_I1, alu_I2); end
    checks++; if (retired_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", retired_cnt); end
    checks++; if (out_result !== 32'd0 || out_illegal !== 1'b0) begin errors++; $display("FAIL reset_out_data got=%h/%b exp=0/0", out_result, out_illegal); end
    #19 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    exp_cnt = 0;
    $display("reset done in_ready=%b out_valid=%b ctrl=%b", in_ready, out_valid, ALU_control);
  endtask

  task automatic test_add();
    out_ready = 1'b1;
    send_op(OP_R, 3'b000, 1'b0, 32'd5, 32'd7, 32'd0, c, i1, i2, ov, r, br, tk, il);
    checks++; if (c !== 4'b0011) begin errors++; $display("FAIL add_ctrl got=%b exp=0011", c); end
    checks++; if (i1 !== 32'd5 || i2 !== 32'd7) begin errors++; $display("FAIL add_operands got=%h/%h exp=5/7", i1, i2); end
    checks++; if (ov !== 1'b1 || r !== 32'd12) begin errors++; $display("FAIL add_result got=%b/%0d exp=1/12", ov, r); end
    checks++; if (retired_cnt !== 16'd1) begin errors++; $display("FAIL add_cnt got=%0d exp=1", retired_cnt); end
    checks++; if (out_valid !== 1'b0 || ALU_control !== 4'b1111) begin errors++; $display("FAIL add_drained got=%b/%b exp=0/1111", out_valid, ALU_control); end
  endtask

  task automatic test_compare();
    send_op(OP_R, 3'b010, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, c, i1, i2, ov, r, br, tk, il);
    checks++; if (c !== 4'b0100 || r !== 32'd1) begin errors++; $display("FAIL slt got=%b/%h exp=0100/1", c, r); end
    send_op(OP_R, 3'b011, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, c, i1, i2, ov, r, br, tk, il);
    checks++; if (c !== 4'b1010 || r !== 32'd0) begin errors++; $display("FAIL sltu got=%b/%h exp=1010/0", c, r); end
    send_op(OP_I, 3'b001, 1'b0, 32'd1, 32'd0, 32'hFFFF_FFE3, c, i1, i2, ov, r, br, tk, il);
    checks++; if (c !== 4'b0110 || i2 !== 32'd3 || r !== 32'd8) begin errors++; $display("FAIL slli got=%b/%h/%h exp=0110/3/8", c, i2, r); end
    send_op(OP_I, 3'b101, 1'b0, 32'h8000_0000, 32'd0, 32'd4, c, i1, i2, ov, r, br, tk, il);
    checks++; if (c !== 4'b0101 || r !== 32'h0800_0000) begin errors++; $display("FAIL srli got=%b/%h exp=0101/08000000", c, r); end
  endtask

  task automatic test_branch();
    send_op(OP_B, 3'b101, 1'b0, 32'h8000_0000, 32'd1, 32'd0, c, i1, i2, ov, r, br, tk, il);
    checks++; if (br !== 1'b1 || tk !== 1'b0 || r !== 32'd0 || c !== 4'b0100) begin errors++; $display("FAIL bge got=br%b tk%b r%h c%b exp=br1 tk0 r0 c0100", br, tk, r, c); end
    send_op(OP_B, 3'b001, 1'b0, 32'd3, 32'd3, 32'd0, c, i1, i2, ov, r, br, tk, il);
    checks++; if (br !== 1'b1 || tk !== 1'b0 || c !== 4'b1011) begin errors++; $display("FAIL bne got=br%b tk%b c%b exp=br1 tk0 c1011", br, tk, c); end
    send_op(OP_B, 3'b110, 1'b0, 32'd1, 32'h8000_0000, 32'd0, c, i1, i2, ov, r, br, tk, il);
    checks++; if (br !== 1'b1 || tk !== 1'b1 || c !== 4'b1010) begin errors++; $display("FAIL bltu got=br%b tk%b c%b exp=br1 tk1 c1010", br, tk, c); end
    send_op(OP_B, 3'b100, 1'b0, 32'hFFFF_FFFE, 32'd2, 32'd0, c, i1, i2, ov, r, br, tk, il);
    checks++; if (tk !== 1'b1) begin errors++; $display("FAIL blt got=tk%b exp=tk1", tk); end
    checks++; if (retired_cnt !== exp_cnt[15:0]) begin errors++; $display("FAIL branch_cnt got=%0d exp=%0d", retired_cnt, exp_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_res [4];
    exp_res[0] = 32'd30; exp_res[1] = 32'd7; exp_res[2] = 32'hFF; exp_res[3] = 32'h3C;
    out_ready = 1'b0;
    set_op(OP_R, 3'b000, 1'b0, 32'd10, 32'd20, 32'd0);
    @(posedge clk); #1;
    set_op(OP_R, 3'b000, 1'b1, 32'd10, 32'd3, 32'd0);
    @(posedge clk); #1;
    set_op(OP_R, 3'b110, 1'b0, 32'hF0, 32'h0F, 32'd0);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_in_ready_low got=%b exp=0", in_ready); end
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1 || out_result !== 32'd30 || ALU_control !== 4'b0100 || in_ready !== 1'b0)
        begin errors++; $display("FAIL b2b_stall%0d got=v%b r%h c%b rdy%b exp=v1 r1e c0100 rdy0", k, out_valid, out_result, ALU_control, in_ready); end
      $display("stall cycle %0d out_result=%h ctrl=%b", k, out_result, ALU_control);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checks++; if (out_valid !== 1'b1 || out_result !== exp_res[k])
        begin errors++; $display("FAIL b2b_out%0d got=v%b r%h exp=v1 r%h", k, out_valid, out_result, exp_res[k]); end
      $display("drain %0d out_result=%h", k, out_result);
      @(posedge clk); #1;
      exp_cnt++;
      if (k == 0) set_op(OP_R, 3'b111, 1'b0, 32'hFF, 32'h3C, 32'd0);
      else in_valid = 1'b0;
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty got=%b exp=0", out_valid); end
    checks++; if (retired_cnt !== exp_cnt[15:0]) begin errors++; $display("FAIL b2b_cnt got=%0d exp=%0d", retired_cnt, exp_cnt); end
  endtask

  task automatic test_illegal();
    send_op(OP_R, 3'b101, 1'b1, 32'h8000_0000, 32'd1, 32'd0, c, i1, i2, ov, r, br, tk, il);
    checks++; if (c !== 4'b1111 || il !== 1'b1 || r !== 32'd0 || ov !== 1'b1) begin errors++; $display("FAIL sra_illegal got=c%b ill%b r%h v%b exp=c1111 ill1 r0 v1", c, il, r, ov); end
    send_op(7'b0000011, 3'b010, 1'b0, 32'd4, 32'd4, 32'd8, c, i1, i2, ov, r, br, tk, il);
    checks++; if (c !== 4'b1111 || il !== 1'b1 || r !== 32'd0 || tk !== 1'b0) begin errors++; $display("FAIL load_illegal got=c%b ill%b r%h tk%b exp=c1111 ill1 r0 tk0", c, il, r, tk); end
    send_op(OP_B, 3'b010, 1'b0, 32'd1, 32'd1, 32'd0, c, i1, i2, ov, r, br, tk, il);
    checks++; if (il !== 1'b1 || br !== 1'b0 || tk !== 1'b0) begin errors++; $display("FAIL br010_illegal got=ill%b br%b tk%b exp=ill1 br0 tk0", il, br, tk); end
    send_op(OP_I, 3'b000, 1'b1, 32'd100, 32'd0, 32'd23, c, i1, i2, ov, r, br, tk, il);
    checks++; if (c !== 4'b0011 || il !== 1'b0 || r !== 32'd123) begin errors++; $display("FAIL add_after_illegal got=c%b ill%b r%0d exp=c0011 ill0 r123", c, il, r); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    set_op(OP_R, 3'b000, 1'b0, 32'd1, 32'd1, 32'd0);
    @(posedge clk); #1;
    set_op(OP_R, 3'b000, 1'b0, 32'd2, 32'd2, 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL mid_full got=v%b rdy%b exp=v1 rdy0", out_valid, in_ready); end
    #3 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || ALU_control !== 4'b1111 || retired_cnt !== 16'd0)
      begin errors++; $display("FAIL mid_async got=v%b c%b cnt%0d exp=v0 c1111 cnt0", out_valid, ALU_control, retired_cnt); end
    exp_cnt = 0;
    @(posedge clk); #3 rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL mid_no_stale got=v%b rdy%b exp=v0 rdy1", out_valid, in_ready); end
    send_op(OP_R, 3'b000, 1'b0, 32'd40, 32'd2, 32'd0, c, i1, i2, ov, r, br, tk, il);
    checks++; if (ov !== 1'b1 || r !== 32'd42 || retired_cnt !== 16'd1) begin errors++; $display("FAIL mid_next_op got=v%b r%0d cnt%0d exp=v1 r42 cnt1", ov, r, retired_cnt); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_compare();
    test_branch();
    test_back_to_back();
    test_illegal();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
